// File: rtl/serial_arith_pkg.sv
// Shared types and constants for the serial arithmetic datapath.
package serial_arith_pkg;

    // Per-word processing state of a serial two's-complement stage
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COPY   = 2'd1,
        INVERT = 2'd2
    } state_e;

    // Per-word mode, sampled on the first bit of a word
    localparam logic MODE_PASS = 1'b0;
    localparam logic MODE_NEG  = 1'b1;

endpackage

// File: rtl/serial_bit_counter.sv
// Bit position counter for one serial word; last_o flags the MSB position.
module serial_bit_counter #(
    parameter int WIDTH = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic en_i,
    output logic last_o
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    // Clear restarts the count; clear together with enable counts the
    // current bit as position 0, leaving the counter at 1.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = en_i ? CW'(1) : '0;
        else if (en_i)
            cnt_d = cnt_q + 1'b1;
    end

    // Count register
    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign last_o = (cnt_q == CW'(WIDTH - 1));

endmodule

// File: rtl/serial_twos_negator.sv
// Framed bit-serial two's-complement negator, LSB first, one-cycle latency.
// Negation copies bits up to and including the first 1, then inverts.
module serial_twos_negator
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic             in_first,
    input  logic             mode,
    output logic             out_valid,
    output logic             out_bit,
    output logic             out_last,
    output logic             word_done,
    output logic [WIDTH-1:0] word_out,
    output logic             overflow
);

    state_e           state_q, state_d;
    logic             mode_q;
    logic             cnt_last;

    // Effective view of the current bit (a start bit overrides the FSM)
    logic             proc;
    logic             is_last;
    state_e           cur_state;
    logic             cur_mode;

    logic             obit;
    logic             ovf_bit;

    logic [WIDTH-1:0] sr_q;
    logic             out_valid_q, out_bit_q, out_last_q, word_done_q, ovf_q;
    logic [WIDTH-1:0] word_out_q;

    serial_bit_counter #(.WIDTH(WIDTH)) u_cnt (
        .clk    (clk),
        .reset  (reset),
        .clr_i  (proc & (in_first | is_last)),
        .en_i   (proc & ~is_last),
        .last_o (cnt_last)
    );

    // Decide whether this bit is processed and in which state/mode;
    // an accepted start bit aborts any word in flight.
    always_comb begin
        proc      = 1'b0;
        is_last   = 1'b0;
        cur_state = state_q;
        cur_mode  = mode_q;
        if (in_valid) begin
            if (in_first) begin
                proc      = 1'b1;
                cur_state = COPY;
                cur_mode  = mode;
            end else if (state_q != IDLE) begin
                proc    = 1'b1;
                is_last = cnt_last;
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // FSM next state: switch to INVERT after the first 1 in negate mode
    always_comb begin
        state_d = state_q;
        if (proc) begin
            if (is_last)
                state_d = IDLE;
            else if (cur_state == COPY && cur_mode == MODE_NEG && in_bit)
                state_d = INVERT;
            else
                state_d = cur_state;
        end
    end

    // FSM outputs: processed bit, and overflow when the MSB is the first 1
    always_comb begin
        obit    = (cur_state == INVERT) ? ~in_bit : in_bit;
        ovf_bit = (cur_mode == MODE_NEG) && (cur_state == COPY) && in_bit;
    end

    // Mode latch, output registers and word shift register
    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q      <= MODE_PASS;
            sr_q        <= '0;
            out_valid_q <= 1'b0;
            out_bit_q   <= 1'b0;
            out_last_q  <= 1'b0;
            word_done_q <= 1'b0;
            word_out_q  <= '0;
            ovf_q       <= 1'b0;
        end else begin
            out_valid_q <= proc;
            out_last_q  <= proc & is_last;
            word_done_q <= proc & is_last;
            if (proc && in_first)
                mode_q <= mode;
            if (proc) begin
                out_bit_q <= obit;
                sr_q      <= {obit, sr_q[WIDTH-1:1]};
            end
            if (proc && is_last) begin
                word_out_q <= {obit, sr_q[WIDTH-1:1]};
                ovf_q      <= ovf_bit;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_bit   = out_bit_q;
    assign out_last  = out_last_q;
    assign word_done = word_done_q;
    assign word_out  = word_out_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_serial_twos_negator.sv
// Self-checking bench for serial_twos_negator (WIDTH=8): directed scenarios
// followed by randomized traffic, against an arithmetic reference model.
module tb_serial_twos_negator;

    localparam int W = 8;
    localparam int MASK = (1 << W) - 1;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic in_valid = 1'b0, in_bit = 1'b0, in_first = 1'b0, mode = 1'b0;
    logic out_valid, out_bit, out_last, word_done, overflow;
    logic [W-1:0] word_out;

    serial_twos_negator #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_bit    (in_bit),
        .in_first  (in_first),
        .mode      (mode),
        .out_valid (out_valid),
        .out_bit   (out_bit),
        .out_last  (out_last),
        .word_done (word_done),
        .word_out  (word_out),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: the word seen so far as an integer; each output bit
    // is the matching bit of that prefix value, negated modulo 2^(idx+1).
    bit         m_active = 0;
    int         m_idx = 0;
    int         m_val = 0;
    bit         m_mode = 0;
    bit         e_valid = 0, e_bit = 0, e_last = 0, e_done = 0, e_ovf = 0;
    logic [W-1:0] e_word = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("out_valid", 32'(out_valid), 32'(e_valid));
        chk("out_bit",   32'(out_bit),   32'(e_bit));
        chk("out_last",  32'(out_last),  32'(e_last));
        chk("word_done", 32'(word_done), 32'(e_done));
        chk("word_out",  32'(word_out),  32'(e_word));
        chk("overflow",  32'(overflow),  32'(e_ovf));
    endtask

    task automatic step(input bit v, input bit b, input bit f, input bit m);
        int res;
        @(negedge clk);
        reset = 1'b0; in_valid = v; in_bit = b; in_first = f; mode = m;
        e_valid = 0; e_last = 0; e_done = 0;
        if (v) begin
            if (f) begin
                m_active = 1; m_idx = 0; m_val = 0; m_mode = m;
            end
            if (m_active) begin
                m_val = m_val | (int'(b) << m_idx);
                res = m_mode ? ((-m_val) & MASK) : m_val;
                e_bit = res[m_idx];
                e_valid = 1;
                if (m_idx == W - 1) begin
                    e_last = 1; e_done = 1;
                    e_word = W'(res);
                    e_ovf = m_mode && (m_val == (1 << (W - 1)));
                    m_active = 0;
                end else begin
                    m_idx++;
                end
            end
        end
        @(posedge clk); #1;
        vectors++;
        check_all();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        in_valid = 1'($urandom); in_bit = 1'($urandom);
        in_first = 1'($urandom); mode = 1'($urandom);
        m_active = 0; m_idx = 0; m_val = 0; m_mode = 0;
        e_valid = 0; e_bit = 0; e_last = 0; e_done = 0; e_word = '0; e_ovf = 0;
        @(posedge clk); #1;
        vectors++;
        check_all();
    endtask

    // Send bits [0..nbits-1] of x; mode toggles randomly after the first bit
    task automatic send_word(input logic [W-1:0] x, input bit md, input int nbits);
        for (int i = 0; i < nbits; i++)
            step(1, x[i], i == 0, (i == 0) ? md : 1'($urandom));
    endtask

    initial begin
        logic [W-1:0] x;
        bit md;

        do_reset();

        // Bits with no start marker in IDLE are dropped
        step(1, 1, 0, 1);
        step(1, 0, 0, 0);

        // Negate 0x05 -> 0xFB
        send_word(8'h05, 1, W);
        chk("neg05_word", 32'(word_out), 32'h0FB);
        chk("neg05_ovf",  32'(overflow), 32'h0);
        step(0, 0, 0, 0);

        // Negate 0x00 and 0x80
        send_word(8'h00, 1, W);
        chk("neg00_word", 32'(word_out), 32'h000);
        chk("neg00_ovf",  32'(overflow), 32'h0);
        send_word(8'h80, 1, W);
        chk("neg80_word", 32'(word_out), 32'h080);
        chk("neg80_ovf",  32'(overflow), 32'h1);

        // Pass 0xA5 then back-to-back negate 0x01
        send_word(8'hA5, 0, W);
        chk("passA5_word", 32'(word_out), 32'h0A5);
        chk("passA5_ovf",  32'(overflow), 32'h0);
        send_word(8'h01, 1, W);
        chk("neg01_word", 32'(word_out), 32'h0FF);

        // Negate 0x05 with a 3-cycle stall after bit 2
        x = 8'h05;
        for (int i = 0; i < W; i++) begin
            step(1, x[i], i == 0, (i == 0) ? 1'b1 : 1'($urandom));
            if (i == 2)
                for (int k = 0; k < 3; k++)
                    step(0, 1'($urandom), 1'($urandom), 1'($urandom));
        end
        chk("stall_word", 32'(word_out), 32'h0FB);

        // Abort at bit 4, then full negate 0x03
        send_word(8'h5A, 1, 4);
        send_word(8'h03, 1, W);
        chk("abort_word", 32'(word_out), 32'h0FD);

        // Reset at bit 5, then a clean word
        send_word(8'h3C, 1, 5);
        do_reset();
        send_word(8'h07, 1, W);
        chk("postrst_word", 32'(word_out), 32'h0F9);

        // Randomized whole words with stalls, aborts and mode changes
        for (int n = 0; n < 60; n++) begin
            x = W'($urandom);
            if ($urandom_range(0, 5) == 0) x = 8'h80;
            if ($urandom_range(0, 7) == 0) x = 8'h00;
            md = 1'($urandom);
            for (int i = 0; i < W; i++) begin
                if (i > 0 && $urandom_range(0, 25) == 0) break;
                step(1, x[i], i == 0, (i == 0) ? md : 1'($urandom));
                while ($urandom_range(0, 5) == 0)
                    step(0, 1'($urandom), 1'($urandom), 1'($urandom));
            end
            if ($urandom_range(0, 3) == 0)
                step(1, 1'($urandom), 0, 1'($urandom));
        end

        // Unstructured random traffic
        for (int n = 0; n < 300; n++)
            step($urandom_range(0, 4) != 0, 1'($urandom),
                 $urandom_range(0, 9) == 0, 1'($urandom));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
